tuser_out_fsm: RTL and testbench
================================

// Module: tuser_out_fsm
// PURPOSE
//  Egress counterpart of the ingress tuple extractor. Takes the 128-bit tuples produced by the SDNet
//  pipeline, queues them in order, and re-attaches each one as TUSER on the first beat of the
//  matching AXIS packet leaving the block. Sits between the SDNet packet/tuple outputs and the
//  downstream AXIS output queues. Packets and tuples pair strictly in FIFO order.
// PARAMETERS
//  DATA_W    256  AXIS TDATA width; TKEEP is DATA_W/8
//  TUPLE_W   128  tuple width, equal to the TUSER width
//  TQ_DEPTH  8    tuple queue depth in entries; must be a power of 2 and at least 2
// PORTS
//  tout_aclk    in   1          single clock for all logic
//  tout_arst    in   1          asynchronous reset, active-low
//  tup_valid    in   1          tuple strobe from SDNet, one tuple per cycle high; no backpressure
//  tup_data     in   TUPLE_W    tuple payload
//  s_avalid     in   1          AXIS in: valid
//  s_adata      in   DATA_W     AXIS in: data
//  s_atkeep     in   DATA_W/8   AXIS in: byte enables
//  s_atlast     in   1          AXIS in: last beat of packet
//  s_aready     out  1          AXIS in: ready
//  m_avalid     out  1          AXIS out: valid
//  m_adata      out  DATA_W     AXIS out: data
//  m_atkeep     out  DATA_W/8   AXIS out: byte enables
//  m_atuser     out  TUPLE_W    AXIS out: tuple on first beat, zero on all other beats
//  m_atlast     out  1          AXIS out: last beat of packet
//  m_aready     in   1          AXIS out: ready
//  tq_count     out  log2(TQ_DEPTH)+1  number of tuples currently queued
//  tq_ovf       out  1          sticky: a tuple was dropped because the queue was full
// BEHAVIOUR
//  Reset (tout_arst=0, async): FSM goes to FIRST. All m_* outputs, tq_count and tq_ovf go to 0.
//   Queue pointers go to 0. s_aready is 0 while reset is asserted.
//  Tuple queue
//   - A write happens on a cycle with tup_valid=1 when count<TQ_DEPTH, or when the queue is full
//     and a pop happens in the same cycle.
//   - A write on a full queue with no same-cycle pop is dropped and sets tq_ovf=1. tq_ovf clears
//     only on reset.
//   - A written entry becomes poppable on the next cycle. There is no same-cycle bypass.
//   - Pointers wrap modulo TQ_DEPTH.
//  Output stage: one registered slot.
//   - slot_free = !m_avalid | m_aready.
//  FSM states
//   - FIRST: s_aready = slot_free & (tq_count!=0).
//     On accept (s_avalid & s_aready): load the beat into the slot, set m_atuser to the head tuple,
//     and pop the queue. If s_atlast=1 (single-beat packet), stay in FIRST; otherwise go to BODY.
//   - BODY: s_aready = slot_free.
//     On accept: load the beat into the slot with m_atuser=0. If s_atlast=1, go to FIRST.
//  Handshake and latency
//   - Latency from s accept to m_avalid=1 is 1 cycle.
//   - Full throughput: 1 beat/cycle while m_aready=1 and a tuple is available at each packet start.
//   - m_* holds stable while m_avalid & !m_aready.
//   - m_avalid drops only after an m accept with no new s accept in the same cycle.
//   - A packet head stalls (s_aready=0) while the queue is empty. Beats in BODY never wait on tuples.
//  Simultaneous events
//   - Push and pop in one cycle: tq_count is unchanged.
//   - Pop and the last beat of a packet in one cycle: legal, FIFO order holds.
//  Reset mid-packet: the partial packet and all queued tuples are discarded. The downstream side
//   sees m_avalid fall asynchronously and the next beat is treated as a packet head.
// STRUCTURE
//  Package tuser_out_pkg: localparams DATA_W/TUPLE_W defaults and the state encoding
//   (ST_FIRST=1'b0, ST_BODY=1'b1).
//  Sub-module tuple_fifo: a sync FIFO with registered count, full, empty and a sticky ovf.
//   It is parameterised by width and depth and is reusable elsewhere in the project.
//  The top level holds the FSM, the output register and the ready logic.
// TESTING
//  1 Push tuple 0xA5..A5, then send a 3-beat packet with m_aready=1
//    -> 3 m beats, m_atuser=0xA5..A5 on beat 0 and 0 on beats 1-2, tq_count 1->0.
//  2 Send a packet head with the queue empty
//    -> s_aready=0 until 1 cycle after tup_valid. The head then exits with that tuple.
//  3 Push TQ_DEPTH+1 tuples back-to-back with no packets
//    -> tq_count=TQ_DEPTH, tq_ovf=1, and the extra tuple does not appear on any later packet.
//  4 Send 4 single-beat packets with tuples T1..T4 queued, and hold m_aready=0 for 5 cycles
//    mid-stream -> m_* stable during the stall, m_atuser order T1,T2,T3,T4, no beat lost or duplicated.
//  5 On a full queue, assert tup_valid on the same cycle a head is accepted
//    -> tuple is stored, tq_count stays TQ_DEPTH, tq_ovf stays 0.
//  6 Assert reset on beat 2 of a 4-beat packet with 2 tuples queued
//    -> all outputs 0. After release, a new packet stalls until a fresh tuple arrives.

Source files
------------

// File: rtl/tuser_out_pkg.sv
// Shared defaults and FSM state encoding for the egress TUSER re-attach block.
package tuser_out_pkg;

  localparam int DATA_W   = 256;
  localparam int TUPLE_W  = 128;
  localparam int TQ_DEPTH = 8;

  typedef logic [0:0] state_t;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_BODY  = 1'b1;

endpackage

// File: rtl/tuser_out_fsm_if.sv
// AXIS bundle (data, keep, user, last) used on both sides of tuser_out_fsm.
// A beat transfers on a rising edge where valid & ready; the master holds its payload while valid & !ready.
interface tuser_out_fsm_if #(
   parameter int DATA_W  = tuser_out_pkg::DATA_W,
   parameter int TUPLE_W = tuser_out_pkg::TUPLE_W
);

   logic                  valid;
   logic [DATA_W-1:0]     data;
   logic [DATA_W/8-1:0]   keep;
   logic [TUPLE_W-1:0]    user;
   logic                  last;
   logic                  ready;

   modport master (output valid, data, keep, user, last, input ready);
   modport slave  (input valid, data, keep, user, last, output ready);

endinterface

// File: rtl/tuple_fifo.sv
// Synchronous FIFO with registered count/full/empty and a sticky overflow flag.
// A push on a full FIFO is kept only if a pop happens in the same cycle; reads are combinational from the head.
module tuple_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_ok;
   logic          wr_ok;
   logic [AW:0]   count_nxt;

   assign pop_ok = pop & !empty;
   assign wr_ok  = push & (!full | pop_ok);
   assign dout   = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (wr_ok && !pop_ok) begin
         count_nxt = count + (AW+1)'(1);
      end else if (!wr_ok && pop_ok) begin
         count_nxt = count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
         if (push && full && !pop_ok) begin
            ovf <= 1'b1;
         end
      end
   end

   // Storage needs no reset: pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/tuser_out_fsm.sv
// Egress stage: queues SDNet tuples and re-attaches each one as TUSER on the first
// beat of the next outgoing AXIS packet, strictly in FIFO order.
module tuser_out_fsm
   import tuser_out_pkg::*;
#(
   parameter int DATA_W   = tuser_out_pkg::DATA_W,
   parameter int TUPLE_W  = tuser_out_pkg::TUPLE_W,
   parameter int TQ_DEPTH = tuser_out_pkg::TQ_DEPTH
) (
   input  logic                       tout_aclk,
   input  logic                       tout_arst,
   input  logic                       tup_valid,
   input  logic [TUPLE_W-1:0]         tup_data,
   tuser_out_fsm_if.slave             s,
   tuser_out_fsm_if.master            m,
   output logic [$clog2(TQ_DEPTH):0]  tq_count,
   output logic                       tq_ovf,
   output logic [0:0]                 fsm_state
);

   logic [0:0]            state;
   logic [TUPLE_W-1:0]    head_tuple;
   logic                  tq_empty;
   logic                  tq_full;
   logic                  slot_free;
   logic                  s_rdy;
   logic                  s_acc;
   logic                  m_acc;
   logic                  tq_pop;

   logic                  m_valid_q;
   logic [DATA_W-1:0]     m_data_q;
   logic [DATA_W/8-1:0]   m_keep_q;
   logic [TUPLE_W-1:0]    m_user_q;
   logic                  m_last_q;

   // Incoming TUSER is replaced by the queued tuple, so it is intentionally ignored.
   logic                  unused_s_user;
   assign unused_s_user = ^s.user;

   assign slot_free = !m_valid_q | m.ready;
   assign s_acc     = s.valid & s_rdy;
   assign m_acc     = m_valid_q & m.ready;
   assign tq_pop    = s_acc & (state == ST_FIRST);

   // A packet head may only enter once its tuple is already committed to the queue.
   always_comb begin
      s_rdy = 1'b0;
      if (tout_arst) begin
         if (state == ST_FIRST) begin
            s_rdy = slot_free & !tq_empty;
         end else begin
            s_rdy = slot_free;
         end
      end
   end

   assign s.ready = s_rdy;

   tuple_fifo #(
      .W     (TUPLE_W),
      .DEPTH (TQ_DEPTH)
   ) u_tuple_fifo (
      .clk   (tout_aclk),
      .rst_n (tout_arst),
      .push  (tup_valid),
      .din   (tup_data),
      .pop   (tq_pop),
      .dout  (head_tuple),
      .count (tq_count),
      .full  (tq_full),
      .empty (tq_empty),
      .ovf   (tq_ovf)
   );

   always_ff @(posedge tout_aclk or negedge tout_arst) begin
      if (!tout_arst) begin
         state <= ST_FIRST;
      end else if (s_acc) begin
         state <= s.last ? ST_FIRST : ST_BODY;
      end
   end

   always_ff @(posedge tout_aclk or negedge tout_arst) begin
      if (!tout_arst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_user_q  <= '0;
         m_last_q  <= 1'b0;
      end else if (s_acc) begin
         m_valid_q <= 1'b1;
         m_data_q  <= s.data;
         m_keep_q  <= s.keep;
         m_user_q  <= (state == ST_FIRST) ? head_tuple : '0;
         m_last_q  <= s.last;
      end else if (m_acc) begin
         m_valid_q <= 1'b0;
      end
   end

   assign m.valid   = m_valid_q;
   assign m.data    = m_data_q;
   assign m.keep    = m_keep_q;
   assign m.user    = m_user_q;
   assign m.last    = m_last_q;
   assign fsm_state = state;

   // Full state is tracked by the FIFO for its own accept logic; the top needs only empty.
   logic unused_tq_full;
   assign unused_tq_full = tq_full;

endmodule

// File: tb/tb_tuser_out_fsm.sv
// Directed bench for tuser_out_fsm: tuple queueing, head stalls, overflow, output stall and reset.
module tb_tuser_out_fsm;
  import tuser_out_pkg::*;

  localparam int DW    = 256;
  localparam int UW    = 128;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SB_W  = UW + 32 + 32 + 1;

  logic          clk;
  logic          rst_n;
  logic          tup_valid;
  logic [UW-1:0] tup_data;
  logic [CW-1:0] tq_count;
  logic          tq_ovf;
  logic [0:0]    fsm_state;

  tuser_out_fsm_if #(.DATA_W(DW), .TUPLE_W(UW)) s_if ();
  tuser_out_fsm_if #(.DATA_W(DW), .TUPLE_W(UW)) m_if ();

  tuser_out_fsm #(.DATA_W(DW), .TUPLE_W(UW), .TQ_DEPTH(DEPTH)) dut (
    .tout_aclk (clk),
    .tout_arst (rst_n),
    .tup_valid (tup_valid),
    .tup_data  (tup_data),
    .s         (s_if),
    .m         (m_if),
    .tq_count  (tq_count),
    .tq_ovf    (tq_ovf),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [SB_W-1:0] beat(input logic [UW-1:0] u, input logic [31:0] d,
                                           input logic last);
    return {u, {8{d[3:0]}}, d, last};
  endfunction

  // scoreboard: every downstream transfer must match the next expected beat
  always @(negedge clk) begin
    if (rst_n && m_if.valid && m_if.ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        logic [SB_W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_beat", {m_if.user, m_if.keep, m_if.data[31:0], m_if.last}, e);
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tuple(input logic [UW-1:0] t);
    tup_valid = 1'b1;
    tup_data  = t;
    tick();
    tup_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    s_if.valid = 1'b1;
    s_if.data  = {{(DW-32){1'b0}}, d};
    s_if.keep  = {8{d[3:0]}};
    s_if.last  = last;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    drive_beat(d, last);
    @(negedge clk);
    while (!s_if.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_accept", s_if.ready, 1);
    tick();
    s_if.valid = 1'b0;
  endtask

  // Head waits on an empty queue, then goes one cycle after the tuple strobe.
  task automatic head_stall(input logic [31:0] d, input logic [UW-1:0] t, input int stall);
    drive_beat(d, 1'b1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("head_stall", s_if.ready, 0);
      tick();
    end
    tup_valid = 1'b1;
    tup_data  = t;
    @(negedge clk);
    chk("head_stall_tup", s_if.ready, 0);
    tick();
    tup_valid = 1'b0;
    @(negedge clk);
    chk("head_go", s_if.ready, 1);
    exp_q.push_back(beat(t, d, 1'b1));
    tick();
    s_if.valid = 1'b0;
  endtask

  localparam logic [UW-1:0] T_A5 = {16{8'hA5}};

  initial begin
    rst_n      = 1'b0;
    tup_valid  = 1'b0;
    tup_data   = '0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.keep  = '0;
    s_if.user  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;

    #12;
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_m_user", m_if.user, 0);
    chk("rst_tq_count", tq_count, 0);
    chk("rst_tq_ovf", tq_ovf, 0);
    chk("rst_s_ready", s_if.ready, 0);
    chk("rst_state", fsm_state, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 3-beat packet with one queued tuple
    push_tuple(T_A5);
    chk("t1_count1", tq_count, 1);
    exp_q.push_back(beat(T_A5, 32'h11, 1'b0));
    exp_q.push_back(beat('0, 32'h12, 1'b0));
    exp_q.push_back(beat('0, 32'h13, 1'b1));
    send_beat(32'h11, 1'b0);
    chk("t1_latency_valid", m_if.valid, 1);
    chk("t1_count0", tq_count, 0);
    chk("t1_state_body", fsm_state, 1);
    send_beat(32'h12, 1'b0);
    send_beat(32'h13, 1'b1);
    chk("t1_state_first", fsm_state, 0);
    repeat (3) tick();
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_idle_valid", m_if.valid, 0);

    // head arrives on empty queue
    head_stall(32'h21, 128'h2222_0000_0000_0000_0000_0000_0000_2222, 3);
    repeat (2) tick();
    chk("t2_drained", exp_q.size(), 0);

    // fill queue exactly, then push and pop in the same cycle while full
    for (int i = 0; i < DEPTH; i++) push_tuple(UW'(32'h300 + i));
    chk("t5_count_full", tq_count, DEPTH);
    chk("t5_ovf_before", tq_ovf, 0);
    tup_valid = 1'b1;
    tup_data  = UW'(32'h5555);
    exp_q.push_back(beat(UW'(32'h300), 32'h51, 1'b1));
    send_beat(32'h51, 1'b1);
    tup_valid = 1'b0;
    chk("t5_count_kept", tq_count, DEPTH);
    chk("t5_ovf_clear", tq_ovf, 0);

    // overflow: extra tuple is dropped
    push_tuple(UW'(32'h9999));
    chk("t3_count_full", tq_count, DEPTH);
    chk("t3_ovf_set", tq_ovf, 1);

    // single-beat packets with a downstream stall mid-stream
    exp_q.push_back(beat(UW'(32'h301), 32'h41, 1'b1));
    exp_q.push_back(beat(UW'(32'h302), 32'h42, 1'b1));
    send_beat(32'h41, 1'b1);
    send_beat(32'h42, 1'b1);
    m_if.ready = 1'b0;
    drive_beat(32'h43, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", m_if.valid, 1);
      chk("t4_stall_user", m_if.user, UW'(32'h302));
      chk("t4_stall_data", m_if.data, 32'h42);
      chk("t4_stall_s_ready", s_if.ready, 0);
      tick();
    end
    m_if.ready = 1'b1;
    exp_q.push_back(beat(UW'(32'h303), 32'h43, 1'b1));
    send_beat(32'h43, 1'b1);
    for (int i = 4; i < DEPTH; i++) begin
      exp_q.push_back(beat(UW'(32'h300 + i), 32'h40 + i, 1'b1));
      send_beat(32'h40 + i, 1'b1);
    end
    exp_q.push_back(beat(UW'(32'h5555), 32'h48, 1'b1));
    send_beat(32'h48, 1'b1);
    repeat (3) tick();
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_count_empty", tq_count, 0);

    // dropped tuple never shows up: next head must stall
    head_stall(32'h49, UW'(32'h6666), 3);
    repeat (2) tick();

    // reset in the middle of a packet with tuples still queued
    push_tuple(UW'(32'h71));
    push_tuple(UW'(32'h72));
    chk("t6_count2", tq_count, 2);
    exp_q.push_back(beat(UW'(32'h71), 32'h61, 1'b0));
    send_beat(32'h61, 1'b0);
    send_beat(32'h62, 1'b0);
    drive_beat(32'h63, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", m_if.valid, 0);
    chk("t6_rst_m_user", m_if.user, 0);
    chk("t6_rst_m_data", m_if.data, 0);
    chk("t6_rst_m_last", m_if.last, 0);
    chk("t6_rst_count", tq_count, 0);
    chk("t6_rst_ovf", tq_ovf, 0);
    chk("t6_rst_s_ready", s_if.ready, 0);
    chk("t6_rst_state", fsm_state, 0);
    s_if.valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    head_stall(32'h81, UW'(32'h8888), 3);
    repeat (3) tick();
    chk("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
